// File: rtl/program_loader.sv
// Boot loader: header N, then N words written to RAM from BASE_ADDR; LOADER_CHECKSUM_EN adds a trailing sum word.
// RAM writes lag accepted words by one cycle; in_ready is decoded from state only, so the source may stall freely.
module program_loader #(
    parameter logic [15:0] BASE_ADDR = 16'h0000,
    parameter logic [15:0] MAX_WORDS = 16'd4096,
    parameter logic [15:0] ADDR_STEP = 16'd2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        in_valid,
    input  logic [15:0] in_data,
    output logic        in_ready,
    output logic [15:0] mem_write_addr,
    output logic [15:0] mem_write_data,
    output logic        mem_en,
    output logic        cpu_hold,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_LOAD,
`ifdef LOADER_CHECKSUM_EN
        S_CHK,
`endif
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] count_q, count_d;
    logic [15:0] ptr_q, ptr_d;
    logic        err_q, err_d;
    logic        wr_en_q, wr_en_d;
    logic [15:0] wr_addr_q, wr_addr_d;
    logic [15:0] wr_data_q, wr_data_d;
`ifdef LOADER_CHECKSUM_EN
    logic [15:0] sum_q, sum_d;
`endif

    logic xfer;

    always_comb begin
        in_ready = (state_q == S_HDR) || (state_q == S_LOAD)
`ifdef LOADER_CHECKSUM_EN
                || (state_q == S_CHK)
`endif
                ;
    end

    assign xfer           = in_valid && in_ready;
    assign busy           = in_ready;
    assign done           = (state_q == S_DONE);
    assign err            = err_q;
    // The CPU is released only from a clean DONE; any error keeps it stalled.
    assign cpu_hold       = !((state_q == S_DONE) && !err_q);
    assign mem_en         = wr_en_q;
    assign mem_write_addr = wr_addr_q;
    assign mem_write_data = wr_data_q;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        ptr_d     = ptr_q;
        err_d     = err_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
`ifdef LOADER_CHECKSUM_EN
        sum_d     = sum_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_HDR;
                    err_d   = 1'b0;
                end
            end
            S_HDR: begin
                if (xfer) begin
`ifdef LOADER_CHECKSUM_EN
                    sum_d = 16'h0000;
`endif
                    if (in_data > MAX_WORDS) begin
                        state_d = S_DONE;
                        err_d   = 1'b1;
                    end else if (in_data == 16'h0000) begin
`ifdef LOADER_CHECKSUM_EN
                        state_d = S_CHK;
`else
                        state_d = S_DONE;
`endif
                    end else begin
                        state_d = S_LOAD;
                        count_d = in_data;
                        ptr_d   = BASE_ADDR;
                    end
                end
            end
            S_LOAD: begin
                if (xfer) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = ptr_q;
                    wr_data_d = in_data;
                    ptr_d     = ptr_q + ADDR_STEP;
                    count_d   = count_q - 16'd1;
`ifdef LOADER_CHECKSUM_EN
                    sum_d     = sum_q + in_data;
`endif
                    if (count_q == 16'd1) begin
`ifdef LOADER_CHECKSUM_EN
                        state_d = S_CHK;
`else
                        state_d = S_DONE;
`endif
                    end
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHK: begin
                if (xfer) begin
                    state_d = S_DONE;
                    err_d   = (in_data != sum_q);
                end
            end
`endif
            S_DONE: begin
                if (start) begin
                    state_d = S_HDR;
                    err_d   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            count_q   <= 16'h0000;
            ptr_q     <= BASE_ADDR;
            err_q     <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= BASE_ADDR;
            wr_data_q <= 16'h0000;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            ptr_q     <= ptr_d;
            err_q     <= err_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

`ifdef LOADER_CHECKSUM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q <= 16'h0000;
        end else begin
            sum_q <= sum_d;
        end
    end
`endif

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: main flow queues expected RAM writes, a monitor pops them on mem_en.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_a, start_b;
    logic        in_valid;
    logic [15:0] in_data;
    logic        sel_b;

    logic        rdy_a, en_a, hold_a, busy_a, done_a, err_a;
    logic [15:0] addr_a, data_a;
    logic        rdy_b, en_b, hold_b, busy_b, done_b, err_b;
    logic [15:0] addr_b, data_b;

    int tests = 0;
    int fails = 0;
    logic [31:0] exp_a[$];
    logic [31:0] exp_b[$];

    always #5 clk = ~clk;

    program_loader u_a (
        .clk(clk), .rst(rst), .start(start_a), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy_a), .mem_write_addr(addr_a), .mem_write_data(data_a), .mem_en(en_a),
        .cpu_hold(hold_a), .busy(busy_a), .done(done_a), .err(err_a)
    );

    program_loader #(.BASE_ADDR(16'hFFFE)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy_b), .mem_write_addr(addr_b), .mem_write_data(data_b), .mem_en(en_b),
        .cpu_hold(hold_b), .busy(busy_b), .done(done_b), .err(err_b)
    );

    task automatic chk1(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every RAM write must match the head of its instance's expected queue.
    always @(negedge clk) begin
        logic [31:0] e;
        if (en_a === 1'b1) begin
            tests++;
            if (exp_a.size() == 0) begin
                fails++;
                $display("FAIL write_a: got addr %h data %h, expected no write", addr_a, data_a);
            end else begin
                e = exp_a.pop_front();
                if ({addr_a, data_a} !== e) begin
                    fails++;
                    $display("FAIL write_a: got addr %h data %h, expected addr %h data %h",
                             addr_a, data_a, e[31:16], e[15:0]);
                end
            end
        end
        if (en_b === 1'b1) begin
            tests++;
            if (exp_b.size() == 0) begin
                fails++;
                $display("FAIL write_b: got addr %h data %h, expected no write", addr_b, data_b);
            end else begin
                e = exp_b.pop_front();
                if ({addr_b, data_b} !== e) begin
                    fails++;
                    $display("FAIL write_b: got addr %h data %h, expected addr %h data %h",
                             addr_b, data_b, e[31:16], e[15:0]);
                end
            end
        end
    end

    task automatic xfer(input logic [15:0] w);
        int t;
        t = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = w;
        while (((sel_b ? rdy_b : rdy_a) !== 1'b1) && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            tests++;
            fails++;
            $display("FAIL xfer_timeout: in_ready got 0 for word %h, expected 1", w);
        end
        @(posedge clk);
    endtask

    task automatic gap(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_data  = 16'hDEAD;
        end
    endtask

    task automatic send_chk(input logic [15:0] sum);
`ifdef LOADER_CHECKSUM_EN
        xfer(sum);
`else
        if (sum === 16'hxxxx) $display("unreachable");
`endif
    endtask

    task automatic settle();
        @(negedge clk);
        in_valid = 1'b0;
        #1;
    endtask

    task automatic pulse_start(input logic b);
        @(negedge clk);
        in_valid = 1'b0;
        if (b) start_b = 1'b1;
        else   start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation got no finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
        in_valid = 1'b0; in_data = 16'h0000; sel_b = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk1("rst_in_ready", rdy_a, 1'b0);
        chk1("rst_mem_en", en_a, 1'b0);
        chk1("rst_busy", busy_a, 1'b0);
        chk1("rst_done", done_a, 1'b0);
        chk1("rst_err", err_a, 1'b0);
        chk1("rst_cpu_hold", hold_a, 1'b1);
        chk16("rst_addr", addr_a, 16'h0000);
        chk16("rst_data", data_a, 16'h0000);
        chk16("rst_addr_b", addr_b, 16'hFFFE);
        @(negedge clk);
        rst = 1'b0;

        // Basic load, in_valid held.
        exp_a.push_back({16'h0000, 16'h1234});
        exp_a.push_back({16'h0002, 16'h5678});
        exp_a.push_back({16'h0004, 16'h9ABC});
        pulse_start(1'b0);
        chk1("basic_busy", busy_a, 1'b1);
        chk1("basic_hold_hdr", hold_a, 1'b1);
        chk1("basic_done_hdr", done_a, 1'b0);
        xfer(16'd3); xfer(16'h1234); xfer(16'h5678); xfer(16'h9ABC);
        send_chk(16'h0368);
        settle();
        chk1("basic_done", done_a, 1'b1);
        chk1("basic_hold", hold_a, 1'b0);
        chk1("basic_err", err_a, 1'b0);
        chk1("basic_busy_done", busy_a, 1'b0);
        @(negedge clk); #1;
        chk16("basic_pending", 16'(exp_a.size()), 16'd0);

        // Restart from DONE; a start pulse mid-LOAD must be ignored.
        pulse_start(1'b0);
        chk1("restart_hold", hold_a, 1'b1);
        chk1("restart_done", done_a, 1'b0);
        chk1("restart_busy", busy_a, 1'b1);
        exp_a.push_back({16'h0000, 16'h1111});
        exp_a.push_back({16'h0002, 16'h2222});
        xfer(16'd2); xfer(16'h1111);
        pulse_start(1'b0);
        chk1("load_start_busy", busy_a, 1'b1);
        xfer(16'h2222);
        send_chk(16'h3333);
        settle();
        chk1("restart_done2", done_a, 1'b1);
        chk1("restart_hold2", hold_a, 1'b0);
        @(negedge clk); #1;
        chk16("restart_pending", 16'(exp_a.size()), 16'd0);

        // Backpressure gaps: valid pattern 1,0,0,1,0,1 over the payload.
        exp_a.push_back({16'h0000, 16'h1234});
        exp_a.push_back({16'h0002, 16'h5678});
        exp_a.push_back({16'h0004, 16'h9ABC});
        pulse_start(1'b0);
        xfer(16'd3);
        xfer(16'h1234); gap(2); xfer(16'h5678); gap(1); xfer(16'h9ABC);
        send_chk(16'h0368);
        settle();
        chk1("gap_done", done_a, 1'b1);
        chk1("gap_hold", hold_a, 1'b0);
        @(negedge clk); #1;
        chk16("gap_pending", 16'(exp_a.size()), 16'd0);

        // Oversize header.
        pulse_start(1'b0);
        xfer(16'd4097);
        settle();
        chk1("big_err", err_a, 1'b1);
        chk1("big_hold", hold_a, 1'b1);
        chk1("big_done", done_a, 1'b1);
        gap(3);

        // Zero-length header; start also clears the sticky error.
        pulse_start(1'b0);
        chk1("zero_err_clear", err_a, 1'b0);
        xfer(16'd0);
        send_chk(16'h0000);
        settle();
        chk1("zero_done", done_a, 1'b1);
        chk1("zero_hold", hold_a, 1'b0);
        chk1("zero_err", err_a, 1'b0);

`ifdef LOADER_CHECKSUM_EN
        exp_a.push_back({16'h0000, 16'h0001});
        exp_a.push_back({16'h0002, 16'hFFFF});
        pulse_start(1'b0);
        xfer(16'd2); xfer(16'h0001); xfer(16'hFFFF); xfer(16'h0000);
        settle();
        chk1("csum_ok_err", err_a, 1'b0);
        chk1("csum_ok_hold", hold_a, 1'b0);
        chk16("csum_ok_pending", 16'(exp_a.size()), 16'd0);
        exp_a.push_back({16'h0000, 16'h0001});
        exp_a.push_back({16'h0002, 16'hFFFF});
        pulse_start(1'b0);
        xfer(16'd2); xfer(16'h0001); xfer(16'hFFFF); xfer(16'h0001);
        settle();
        chk1("csum_bad_err", err_a, 1'b1);
        chk1("csum_bad_hold", hold_a, 1'b1);
        chk1("csum_bad_done", done_a, 1'b1);
        chk16("csum_bad_pending", 16'(exp_a.size()), 16'd0);
`endif

        // Address wrap on the BASE_ADDR=FFFE instance.
        sel_b = 1'b1;
        exp_b.push_back({16'hFFFE, 16'hAAAA});
        exp_b.push_back({16'h0000, 16'h5555});
        pulse_start(1'b1);
        chk1("wrap_busy", busy_b, 1'b1);
        xfer(16'd2); xfer(16'hAAAA); xfer(16'h5555);
        send_chk(16'hFFFF);
        settle();
        chk1("wrap_done", done_b, 1'b1);
        chk1("wrap_hold", hold_b, 1'b0);
        @(negedge clk); #1;
        chk16("wrap_pending", 16'(exp_b.size()), 16'd0);
        sel_b = 1'b0;

        // Mid-session reset after 2 of 5 words, then a fresh load.
        exp_a.push_back({16'h0000, 16'h00A1});
        exp_a.push_back({16'h0002, 16'h00A2});
        pulse_start(1'b0);
        xfer(16'd5); xfer(16'h00A1); xfer(16'h00A2);
        settle();
        rst = 1'b1;
        #1;
        chk1("mid_in_ready", rdy_a, 1'b0);
        chk1("mid_mem_en", en_a, 1'b0);
        chk1("mid_hold", hold_a, 1'b1);
        chk1("mid_busy", busy_a, 1'b0);
        chk16("mid_addr", addr_a, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        exp_a.push_back({16'h0000, 16'h00B1});
        exp_a.push_back({16'h0002, 16'h00B2});
        pulse_start(1'b0);
        xfer(16'd2); xfer(16'h00B1); xfer(16'h00B2);
        send_chk(16'h0163);
        settle();
        chk1("reload_done", done_a, 1'b1);
        chk1("reload_hold", hold_a, 1'b0);
        @(negedge clk); #1;
        chk16("reload_pending", 16'(exp_a.size()), 16'd0);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
